// File: rtl/neureka_streamer_sched.sv
// Streamer transfer scheduler: round-robin arbitration over five requesters
// (four load streams plus the store stream), a SETUP/START/WAIT/DRAIN
// sequence per transfer, and a sticky timeout error that is left via clear_i.
module neureka_streamer_sched #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [4:0] req_i,
    input  logic       source_done_i,
    input  logic       sink_done_i,
    input  logic       tcdm_fifo_empty_i,
    output logic [1:0] ld_which_sel_o,
    output logic       ld_st_sel_o,
    output logic       clear_source_o,
    output logic       clear_sink_o,
    output logic       start_o,
    output logic [4:0] ack_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, START, WAIT, DRAIN, ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q;       // round-robin start point, 0..4
    logic [2:0]    g_q;         // index of the active transfer
    logic [CW-1:0] cnt_q;       // WAIT cycle counter
    logic          err_entry_q; // first cycle in ERROR
    logic          grant_vld;
    logic [2:0]    grant_idx;
    logic          done_sel;

    // (p + o) mod 5 for p in 0..4 and o in 0..4
    function automatic logic [2:0] wrap5(input logic [2:0] p, input int o);
        int s;
        s = int'(p) + o;
        if (s >= 5) s = s - 5;
        return 3'(s);
    endfunction

    // First requester at or after ptr; scanning offsets downward lets the
    // smallest offset win.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (req_i[wrap5(ptr_q, i)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap5(ptr_q, i);
            end
        end
    end

    // The store transfer completes on the sink side, loads on the source side.
    assign done_sel = (g_q == 3'd4) ? sink_done_i : source_done_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; clear_i overrides every transition
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable_i && grant_vld) state_d = SETUP;
                SETUP:   state_d = START;
                START:   state_d = WAIT;
                WAIT: begin
                    // done in the last counted cycle still wins over timeout
                    if (done_sel)               state_d = DRAIN;
                    else if (cnt_q == CNT_LAST) state_d = ERROR;
                end
                DRAIN:   if (tcdm_fifo_empty_i) state_d = IDLE;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Grant latch, pointer, stream selects, WAIT counter, error-entry flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q          <= 3'd0;
            g_q            <= 3'd0;
            cnt_q          <= '0;
            err_entry_q    <= 1'b0;
            ld_which_sel_o <= 2'd0;
            ld_st_sel_o    <= 1'b0;
        end else if (clear_i) begin
            ptr_q       <= 3'd0;
            cnt_q       <= '0;
            err_entry_q <= 1'b0;
        end else begin
            err_entry_q <= (state_q != ERROR) && (state_d == ERROR);
            cnt_q       <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            // Selects are loaded on the grant edge so they are valid in SETUP
            // and then hold until the next grant.
            if (state_q == IDLE && state_d == SETUP) begin
                g_q         <= grant_idx;
                ptr_q       <= (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
                ld_st_sel_o <= (grant_idx == 3'd4);
                if (grant_idx != 3'd4) ld_which_sel_o <= grant_idx[1:0];
            end
        end
    end

    // Outputs decoded from state; pulses suppressed while clear_i is high
    always_comb begin
        start_o        = 1'b0;
        clear_source_o = 1'b0;
        clear_sink_o   = 1'b0;
        ack_o          = 5'd0;
        busy_o         = (state_q != IDLE) && (state_q != ERROR);
        err_o          = (state_q == ERROR);
        if (!clear_i) begin
            start_o        = (state_q == START);
            clear_source_o = ((state_q == SETUP) && (g_q != 3'd4)) || err_entry_q;
            clear_sink_o   = ((state_q == SETUP) && (g_q == 3'd4)) || err_entry_q;
            if (state_q == DRAIN && tcdm_fifo_empty_i) ack_o = 5'b00001 << g_q;
        end
    end

endmodule

// File: doc/neureka_streamer_sched.md
NEUREKA_STREAMER_SCHED -- requirements
Module: neureka_streamer_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: WAIT-state cycles before a transfer is declared hung (must be >= 2).
REQ-002 SHALL have clk_i, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have rst_ni, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have clear_i, input, 1: synchronous soft clear.
REQ-005 SHALL have enable_i, input, 1: permits new grants.
REQ-006 SHALL have req_i, input, 5: transfer requests, index 0 feat, 1 weight, 2 norm, 3 streamin, 4 store.
REQ-007 SHALL have source_done_i / sink_done_i, input, 1 each: streamer source / sink completion flags.
REQ-008 SHALL have tcdm_fifo_empty_i, input, 1: streamer TCDM FIFO empty flag.
REQ-009 SHALL have ld_which_sel_o, output, 2: selected load stream index 0..3.
REQ-010 SHALL have ld_st_sel_o, output, 1: 1 = store (sink) path, 0 = load path.
REQ-011 SHALL have clear_source_o / clear_sink_o, output, 1 each: streamer clear pulses.
REQ-012 SHALL have start_o, output, 1: one-cycle transfer start pulse.
REQ-013 SHALL have ack_o, output, 5: one-hot completion pulse per requester.
REQ-014 SHALL have busy_o, output, 1: high in any state except IDLE and ERROR.
REQ-015 SHALL have err_o, output, 1: sticky timeout error.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, START, WAIT, DRAIN, ERROR.
REQ-017 IDLE -> SETUP SHALL occur when enable_i=1 and req_i!=0; grant = first set bit of req_i at or after round-robin pointer ptr, wrapping 4->0.
REQ-018 On grant SHALL latch index g, set ptr = (g+1) mod 5; later req_i changes SHALL not affect the active transfer.
REQ-019 SETUP (1 cycle) SHALL drive registered ld_st_sel_o=(g==4), ld_which_sel_o=g[1:0] for g<4 (unchanged for g=4), and pulse clear_source_o if g<4 else clear_sink_o.
REQ-020 START (1 cycle) SHALL pulse start_o; done inputs SHALL be ignored in SETUP and START.
REQ-021 WAIT SHALL exit to DRAIN when the relevant done (source_done_i for g<4, sink_done_i for g=4) is 1; the other done input SHALL be ignored.
REQ-022 WAIT SHALL count cycles from 0; on count==TIMEOUT_CYCLES-1 without done SHALL go to ERROR; done in that same cycle SHALL win (go to DRAIN).
REQ-023 DRAIN SHALL wait for tcdm_fifo_empty_i=1, then pulse ack_o[g] for that cycle and return to IDLE; earliest next SETUP is the following cycle.
REQ-024 Latency grant->start_o SHALL be exactly 2 cycles (IDLE sample, SETUP, START).
REQ-025 ERROR SHALL hold err_o=1, pulse clear_source_o and clear_sink_o on entry cycle only, and stay until clear_i.
REQ-026 ld_which_sel_o / ld_st_sel_o SHALL hold their last value outside SETUP updates.
REQ-027 enable_i=0 SHALL block grants in IDLE only; an active transfer SHALL complete normally.
REQ-028 clear_i SHALL take priority over all transitions: next state IDLE, ptr=0, counter=0, err_o=0, no pulses that cycle.
REQ-029 Pulse outputs (start_o, clear_*_o, ack_o) SHALL be high for exactly one cycle per event and never simultaneously with another transfer's pulses.

Reset
REQ-030 On rst_ni=0 SHALL asynchronously force IDLE, ptr=0, counter=0, all outputs 0 (ld_which_sel_o=0, ld_st_sel_o=0, err_o=0, busy_o=0, ack_o=0).
REQ-031 Reset mid-transfer SHALL abandon the transfer with no ack_o pulse.

Verification
REQ-032 req_i=5'b00010, source_done_i 5 cycles after start_o, fifo empty -> ld_which_sel_o=1, ld_st_sel_o=0, clear_source_o then start_o on next cycle, ack_o=5'b00010 one cycle after done.
REQ-033 req_i=5'b11111 held, done immediate each time -> grant order 0,1,2,3,4,0; store grant shows ld_st_sel_o=1, clear_sink_o.
REQ-034 TIMEOUT_CYCLES=8, no done -> ERROR after 8 WAIT cycles, err_o=1, both clears pulsed once, no ack; clear_i -> IDLE, err_o=0.
REQ-035 done asserted at WAIT count 7 with TIMEOUT_CYCLES=8 -> DRAIN, ack, err_o stays 0.
REQ-036 done with tcdm_fifo_empty_i=0 for 3 cycles -> ack_o delayed 3 cycles, busy_o high throughout.
REQ-037 rst_ni low during WAIT -> immediate IDLE, outputs 0, no ack; enable_i=0 with pending req -> no grant until enable_i=1.
